n64_pi_write_packer: RTL

N64_PI_WRITE_PACKER -- requirements
Module: n64_pi_write_packer

---
 rtl/n64_pi_pkg.sv | 23 ++
 rtl/if_system.sv | 13 +
 rtl/n64_pi_write_packer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/n64_pi_pkg.sv
// n64_pi_pkg
//    Shared types and constants for the PI write path.
//    e_packer_state : packer FSM state encoding
//    ADDR_STEP      : byte increment between consecutive 32-bit writes
//    PAD_HALF       : filler for the low half of a partial word
//    align_word()   : clears the byte-lane bits of an address
package n64_pi_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FILL_HI = 2'd1,
      FILL_LO = 2'd2,
      REQ     = 2'd3
   } e_packer_state;

   localparam logic [31:0] ADDR_STEP = 32'd4;
   localparam logic [15:0] PAD_HALF  = 16'h0000;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_system.sv
// if_system
//    Bundles the system clock and synchronous active-high reset.
//    clk   : single system clock, all logic on its rising edge
//    reset : synchronous, active-high
interface if_system;
   logic clk;
   logic reset;

   modport sys (
      input clk,
      input reset
   );
endinterface

// File: rtl/n64_pi_write_packer.sv
// n64_pi_write_packer
//    Packs pairs of 16-bit halfwords popped from the PI write FIFO into
//    32-bit memory writes at consecutive word addresses.
//    Optional build macro: N64_PI_PACKER_WMASK_EN adds the mem_wmask port
//    (4'b1111 full word, 4'b1100 zero-padded partial word).
//
//    sys            : clock / synchronous reset bundle
//    start          : one-cycle pulse, begins a transfer (accepted in IDLE only)
//    start_address  : byte address sampled on accepted start, bits [1:0] dropped
//    finish         : one-cycle pulse, no further halfwords will arrive
//    fifo_flush     : flush strobe to the FIFO, the cycle a start is accepted
//    fifo_empty     : FIFO has no data
//    fifo_read      : pop the FIFO head this cycle
//    fifo_rdata     : combinational FIFO head data
//    mem_request    : write request, held until mem_ack
//    mem_ack        : write accepted
//    mem_address    : word-aligned write address
//    mem_wdata      : write data, first halfword in [31:16]
//    busy           : high whenever the FSM is not in IDLE
//    mem_wmask      : byte enables (only with N64_PI_PACKER_WMASK_EN)
//
//    state   | meaning
//    --------+-----------------------------------------------------------
//    IDLE    | waiting for start
//    FILL_HI | waiting for the halfword that lands in wdata[31:16]
//    FILL_LO | waiting for the halfword that lands in wdata[15:0]
//    REQ     | write presented on the memory port until acked
module n64_pi_write_packer
   import n64_pi_pkg::*;
(
   if_system.sys        sys,
   input  logic         start,
   input  logic [31:0]  start_address,
   input  logic         finish,
   output logic         fifo_flush,
   input  logic         fifo_empty,
   output logic         fifo_read,
   input  logic [15:0]  fifo_rdata,
   output logic         mem_request,
   input  logic         mem_ack,
   output logic [31:0]  mem_address,
   output logic         busy,
   output logic [31:0]  mem_wdata
`ifdef N64_PI_PACKER_WMASK_EN
   ,
   output logic [3:0]   mem_wmask
`endif
);

   e_packer_state state;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic          partial_q;
   logic          finish_pending;
   logic          fill_state;

`ifdef N64_PI_PACKER_WMASK_EN
   logic [3:0]    wmask_q;
   assign mem_wmask = wmask_q;
`endif

   assign fill_state  = (state == FILL_HI) || (state == FILL_LO);
   assign fifo_read   = fill_state && !fifo_empty;
   // Flush in the accepting cycle itself, while still in IDLE, so a pop can
   // never coincide with it.
   assign fifo_flush  = (state == IDLE) && start && !sys.reset;
   assign mem_request = (state == REQ);
   assign busy        = (state != IDLE);
   assign mem_address = addr_q;
   assign mem_wdata   = wdata_q;

   always_ff @(posedge sys.clk) begin
      if (sys.reset) begin
         state          <= IDLE;
         addr_q         <= '0;
         wdata_q        <= '0;
         partial_q      <= 1'b0;
         finish_pending <= 1'b0;
`ifdef N64_PI_PACKER_WMASK_EN
         wmask_q        <= 4'b0000;
`endif
      end else begin
         if (finish && (state != IDLE)) begin
            finish_pending <= 1'b1;
         end

         case (state)
            IDLE: begin
               finish_pending <= 1'b0;
               if (start) begin
                  state     <= FILL_HI;
                  addr_q    <= align_word(start_address);
                  partial_q <= 1'b0;
               end
            end

            // An available halfword always wins over draining on finish.
            FILL_HI: begin
               if (!fifo_empty) begin
                  wdata_q[31:16] <= fifo_rdata;
                  state          <= FILL_LO;
               end else if (finish_pending) begin
                  finish_pending <= 1'b0;
                  state          <= IDLE;
               end
            end

            FILL_LO: begin
               if (!fifo_empty) begin
                  wdata_q[15:0] <= fifo_rdata;
                  partial_q     <= 1'b0;
`ifdef N64_PI_PACKER_WMASK_EN
                  wmask_q       <= 4'b1111;
`endif
                  state         <= REQ;
               end else if (finish_pending) begin
                  wdata_q[15:0] <= PAD_HALF;
                  partial_q     <= 1'b1;
`ifdef N64_PI_PACKER_WMASK_EN
                  wmask_q       <= 4'b1100;
`endif
                  state         <= REQ;
               end
            end

            REQ: begin
               if (mem_ack) begin
                  addr_q <= addr_q + ADDR_STEP;
                  if (partial_q) begin
                     finish_pending <= 1'b0;
                     state          <= IDLE;
                  end else begin
                     state <= FILL_HI;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
